// File: rtl/or4_event_monitor_if.sv
// or4_event_monitor_if: bundles the request lines, the sample controls and the
// monitor results of or4_event_monitor.
//   master : drives a,b,c,d,en,clr and observes e,rise,count,sat,first
//   slave  : the monitor side (receives requests and produces results)
// CW sets the width of the event counter (2..16).
interface or4_event_monitor_if #(
  parameter int CW = 8
);
  logic          a;
  logic          b;
  logic          c;
  logic          d;
  logic          en;
  logic          clr;
  logic          e;
  logic          rise;
  logic [CW-1:0] count;
  logic          sat;
  logic [3:0]    first;

  modport master (
    output a, b, c, d, en, clr,
    input  e, rise, count, sat, first
  );

  modport slave (
    input  a, b, c, d, en, clr,
    output e, rise, count, sat, first
  );
endinterface

// File: rtl/or4_event_monitor.sv
// or4_event_monitor: OR-reduces four request lines and filters the result so
// that only a request held for at least two enabled samples counts as an event.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high; returns everything to IDLE/zero
//   bus   - or4_event_monitor_if.slave
//           a,b,c,d in  : request lines
//           en      in  : sample enable (0 freezes all state, rise forced 0)
//           clr     in  : synchronous clear of count, sat and first
//           e       out : filtered OR (high while ACTIVE)
//           rise    out : one-cycle pulse per accepted event
//           count   out : saturating accepted-event counter (CW bits)
//           sat     out : count is at its maximum
//           first   out : {a,b,c,d} of the first event since reset/clr
module or4_event_monitor #(
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  or4_event_monitor_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  // Counter increment that sticks at the maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t        state_p0;
  logic          e_p0;
  logic          rise_p0;
  logic [CW-1:0] count_p0;
  logic          sat_p0;
  logic [3:0]    first_p0;

  logic          s;
  logic [3:0]    req;
  logic [CW-1:0] count_inc;

  assign req       = {bus.a, bus.b, bus.c, bus.d};
  assign s         = |req;
  assign count_inc = sat_inc(count_p0);

  // Stage p0: filter FSM and event bookkeeping, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= IDLE;
      e_p0     <= 1'b0;
      rise_p0  <= 1'b0;
      count_p0 <= '0;
      sat_p0   <= 1'b0;
      first_p0 <= 4'b0000;
    end else begin
      rise_p0 <= 1'b0;
      if (bus.en) begin
        case (state_p0)
          IDLE: begin
            if (s) state_p0 <= PEND;
          end
          PEND: begin
            if (s) begin
              // Second consecutive high sample: the accepted event.
              state_p0 <= ACTIVE;
              e_p0     <= 1'b1;
              rise_p0  <= 1'b1;
              count_p0 <= count_inc;
              sat_p0   <= (count_inc == CNT_MAX);
              if (count_p0 == '0) first_p0 <= req;
            end else begin
              state_p0 <= IDLE;
            end
          end
          ACTIVE: begin
            if (!s) begin
              state_p0 <= IDLE;
              e_p0     <= 1'b0;
            end
          end
          default: begin
            state_p0 <= IDLE;
            e_p0     <= 1'b0;
          end
        endcase
      end
      // Placed last so a clear overrides a simultaneous event update, while
      // leaving the FSM, e and rise untouched.
      if (bus.clr) begin
        count_p0 <= '0;
        sat_p0   <= 1'b0;
        first_p0 <= 4'b0000;
      end
    end
  end

  assign bus.e     = e_p0;
  assign bus.rise  = rise_p0;
  assign bus.count = count_p0;
  assign bus.sat   = sat_p0;
  assign bus.first = first_p0;

endmodule
